// File: rtl/rf_wb_sched.sv
// Write-back scheduler for the 32x32 register file: round-robin arbitration of N
// requesters onto the single write port, plus a per-register pending-write scoreboard.
module rf_wb_sched #(
  parameter int N     = 3,
  parameter int CNT_W = 2
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [N-1:0]    REQ_VALID,
  input  logic [5*N-1:0]  REQ_ADDR,
  input  logic [32*N-1:0] REQ_DATA,
  output logic [N-1:0]    REQ_READY,
  input  logic            ISSUE,
  input  logic [4:0]      ISSUE_ADDR,
  output logic            ISSUE_READY,
  input  logic [4:0]      CHK_ADDR_1,
  input  logic [4:0]      CHK_ADDR_2,
  output logic            BUSY_1,
  output logic            BUSY_2,
  output logic            PENDING,
  output logic            WE,
  output logic [4:0]      WR_ADDR,
  output logic [31:0]     W_DATA
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic [N-1:0]     grant;
  logic             found;
  logic             xfer;
  logic [4:0]       sel_addr;
  logic [31:0]      sel_data;
  logic [CNT_W-1:0] cnt [1:31];
  logic             issue_go;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return s[IDX_W-1:0];
  endfunction

  // Counter lookup with r0 reading as permanently zero.
  function automatic logic [CNT_W-1:0] cnt_of(input logic [4:0] addr);
    logic [CNT_W-1:0] v;
    v = '0;
    for (int r = 1; r < 32; r++)
      if (addr == 5'(r)) v = cnt[r];
    return v;
  endfunction

  always_comb begin
    grant   = '0;
    gnt_idx = last;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = rr_idx(last, k);
      if (!found && REQ_VALID[cand]) begin
        found        = 1'b1;
        grant[cand]  = 1'b1;
        gnt_idx      = cand;
      end
    end
    sel_addr = REQ_ADDR[int'(gnt_idx)*5 +: 5];
    sel_data = REQ_DATA[int'(gnt_idx)*32 +: 32];
  end

  assign REQ_READY = grant;
  assign xfer      = found;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last    <= LAST_RST;
      WE      <= 1'b0;
      WR_ADDR <= '0;
      W_DATA  <= '0;
    end else if (xfer) begin
      last <= gnt_idx;
      if (sel_addr != 5'd0) begin
        WE      <= 1'b1;
        WR_ADDR <= sel_addr;
        W_DATA  <= sel_data;
      end else begin
        WE      <= 1'b0;
        WR_ADDR <= '0;
        W_DATA  <= '0;
      end
    end else begin
      // Idle address parks at r0 so downstream bypass compares never match.
      WE      <= 1'b0;
      WR_ADDR <= '0;
      W_DATA  <= '0;
    end
  end

  assign ISSUE_READY = (ISSUE_ADDR == 5'd0) || (cnt_of(ISSUE_ADDR) != CNT_MAX);
  assign issue_go    = ISSUE && ISSUE_READY && (ISSUE_ADDR != 5'd0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 1; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        logic inc, dec;
        inc = issue_go && (ISSUE_ADDR == 5'(r));
        dec = WE && (WR_ADDR == 5'(r)) && (cnt[r] != '0);
        if (inc && !dec)      cnt[r] <= cnt[r] + 1'b1;
        else if (dec && !inc) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  assign BUSY_1 = (CHK_ADDR_1 != 5'd0) && (cnt_of(CHK_ADDR_1) != '0);
  assign BUSY_2 = (CHK_ADDR_2 != 5'd0) && (cnt_of(CHK_ADDR_2) != '0);

  always_comb begin
    PENDING = 1'b0;
    for (int r = 1; r < 32; r++)
      if (cnt[r] != '0) PENDING = 1'b1;
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched (N=3, CNT_W=2): arbitration order, scoreboard
// hazards, saturation, same-edge inc/dec, r0 handling and asynchronous reset.
module tb_rf_wb_sched;

  localparam int N = 3;
  localparam int CNT_W = 2;

  logic            CLK;
  logic            RESET_N;
  logic [N-1:0]    REQ_VALID;
  logic [5*N-1:0]  REQ_ADDR;
  logic [32*N-1:0] REQ_DATA;
  logic [N-1:0]    REQ_READY;
  logic            ISSUE;
  logic [4:0]      ISSUE_ADDR;
  logic            ISSUE_READY;
  logic [4:0]      CHK_ADDR_1, CHK_ADDR_2;
  logic            BUSY_1, BUSY_2, PENDING, WE;
  logic [4:0]      WR_ADDR;
  logic [31:0]     W_DATA;

  int vec = 0;
  int errs = 0;

  rf_wb_sched #(.N(N), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
    .ISSUE(ISSUE), .ISSUE_ADDR(ISSUE_ADDR), .ISSUE_READY(ISSUE_READY),
    .CHK_ADDR_1(CHK_ADDR_1), .CHK_ADDR_2(CHK_ADDR_2),
    .BUSY_1(BUSY_1), .BUSY_2(BUSY_2), .PENDING(PENDING),
    .WE(WE), .WR_ADDR(WR_ADDR), .W_DATA(W_DATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    REQ_ADDR[5*i +: 5]  = a;
    REQ_DATA[32*i +: 32] = d;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0;
    ISSUE = 1'b0; ISSUE_ADDR = '0; CHK_ADDR_1 = '0; CHK_ADDR_2 = '0;
    #2;
    vec++; if ({WE, WR_ADDR, W_DATA} !== 38'd0) begin errs++; $display("FAIL reset_outputs got we=%b addr=%0d data=%h exp 0/0/0", WE, WR_ADDR, W_DATA); end
    vec++; if ({PENDING, BUSY_1, BUSY_2, ISSUE_READY} !== 4'b0001) begin errs++; $display("FAIL reset_status got %b exp 0001", {PENDING, BUSY_1, BUSY_2, ISSUE_READY}); end
    @(negedge CLK);
    RESET_N = 1'b1;
    REQ_VALID = 3'b111;
    #1;
    vec++; if (REQ_READY !== 3'b001) begin errs++; $display("FAIL reset_first_grant got %b exp 001", REQ_READY); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy;
    logic [4:0] exp_a;
    set_req(0, 5'd5, 32'h1000_0000);
    set_req(1, 5'd6, 32'h1000_0001);
    set_req(2, 5'd7, 32'h1000_0002);
    REQ_VALID = 3'b111;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_rdy = 3'b001 << (i % 3);
      exp_a   = 5'(5 + (i % 3));
      vec++; if (REQ_READY !== exp_rdy) begin errs++; $display("FAIL rr_ready[%0d] got %b exp %b", i, REQ_READY, exp_rdy); end
      step();
      vec++; if ({WE, WR_ADDR, W_DATA} !== {1'b1, exp_a, 32'h1000_0000 + 32'(i % 3)})
        begin errs++; $display("FAIL rr_write[%0d] got we=%b addr=%0d data=%h exp 1/%0d/%h", i, WE, WR_ADDR, W_DATA, exp_a, 32'h1000_0000 + 32'(i % 3)); end
    end
    REQ_VALID = '0;
    step();
    vec++; if ({WE, WR_ADDR, W_DATA} !== 38'd0) begin errs++; $display("FAIL rr_idle got we=%b addr=%0d data=%h exp 0/0/0", WE, WR_ADDR, W_DATA); end
  endtask

  task automatic test_scoreboard();
    ISSUE = 1'b1; ISSUE_ADDR = 5'd9; CHK_ADDR_1 = 5'd9;
    #1;
    vec++; if ({ISSUE_READY, BUSY_1} !== 2'b10) begin errs++; $display("FAIL sb_t0 got rdy/busy=%b exp 10", {ISSUE_READY, BUSY_1}); end
    step();
    ISSUE = 1'b0;
    vec++; if ({BUSY_1, PENDING} !== 2'b11) begin errs++; $display("FAIL sb_t1 got busy/pend=%b exp 11", {BUSY_1, PENDING}); end
    step();
    step();
    set_req(1, 5'd9, 32'hDEAD_BEEF);
    REQ_VALID = 3'b010;
    #1;
    vec++; if (REQ_READY !== 3'b010) begin errs++; $display("FAIL sb_grant got %b exp 010", REQ_READY); end
    step();
    REQ_VALID = '0;
    vec++; if ({WE, WR_ADDR, W_DATA, BUSY_1} !== {1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1})
      begin errs++; $display("FAIL sb_t4 got we=%b addr=%0d data=%h busy=%b exp 1/9/deadbeef/1", WE, WR_ADDR, W_DATA, BUSY_1); end
    step();
    vec++; if ({BUSY_1, PENDING, WE} !== 3'b000) begin errs++; $display("FAIL sb_t5 got busy/pend/we=%b exp 000", {BUSY_1, PENDING, WE}); end
  endtask

  task automatic test_saturation();
    ISSUE = 1'b1; ISSUE_ADDR = 5'd4; CHK_ADDR_2 = 5'd4;
    step(); step(); step();
    vec++; if (ISSUE_READY !== 1'b0) begin errs++; $display("FAIL sat_ready_r4 got %b exp 0", ISSUE_READY); end
    step();
    ISSUE = 1'b0;
    #1;
    vec++; if ({ISSUE_READY, BUSY_2} !== 2'b01) begin errs++; $display("FAIL sat_ignored got rdy/busy=%b exp 01", {ISSUE_READY, BUSY_2}); end
    ISSUE_ADDR = 5'd5;
    #1;
    vec++; if (ISSUE_READY !== 1'b1) begin errs++; $display("FAIL sat_ready_r5 got %b exp 1", ISSUE_READY); end
    set_req(2, 5'd4, 32'h0000_0044);
    REQ_VALID = 3'b100;
    step();
    step();
    vec++; if (BUSY_2 !== 1'b1) begin errs++; $display("FAIL sat_busy_after1 got %b exp 1", BUSY_2); end
    step();
    REQ_VALID = '0;
    vec++; if ({BUSY_2, WE, WR_ADDR} !== {1'b1, 1'b1, 5'd4}) begin errs++; $display("FAIL sat_busy_after2 got busy/we/addr=%b/%b/%0d exp 1/1/4", BUSY_2, WE, WR_ADDR); end
    step();
    vec++; if ({BUSY_2, PENDING} !== 2'b00) begin errs++; $display("FAIL sat_clear got busy/pend=%b exp 00", {BUSY_2, PENDING}); end
  endtask

  task automatic test_simultaneous();
    CHK_ADDR_1 = 5'd12;
    ISSUE = 1'b1; ISSUE_ADDR = 5'd12;
    set_req(0, 5'd12, 32'h0000_0C0C);
    REQ_VALID = 3'b001;
    #1;
    vec++; if (REQ_READY !== 3'b001) begin errs++; $display("FAIL sim_grant got %b exp 001", REQ_READY); end
    step();
    REQ_VALID = '0;
    vec++; if ({BUSY_1, WE, WR_ADDR} !== {1'b1, 1'b1, 5'd12}) begin errs++; $display("FAIL sim_pre got busy/we/addr=%b/%b/%0d exp 1/1/12", BUSY_1, WE, WR_ADDR); end
    step();
    ISSUE = 1'b0;
    vec++; if ({BUSY_1, WE} !== 2'b10) begin errs++; $display("FAIL sim_same_edge got busy/we=%b exp 10", {BUSY_1, WE}); end
    step();
    vec++; if (BUSY_1 !== 1'b1) begin errs++; $display("FAIL sim_hold got %b exp 1", BUSY_1); end
    REQ_VALID = 3'b001;
    step();
    REQ_VALID = '0;
    step();
    vec++; if ({BUSY_1, PENDING} !== 2'b00) begin errs++; $display("FAIL sim_clear got busy/pend=%b exp 00", {BUSY_1, PENDING}); end
  endtask

  task automatic test_r0();
    ISSUE = 1'b1; ISSUE_ADDR = 5'd0; CHK_ADDR_1 = 5'd0; CHK_ADDR_2 = 5'd0;
    #1;
    vec++; if ({ISSUE_READY, BUSY_1, BUSY_2} !== 3'b100) begin errs++; $display("FAIL r0_issue got %b exp 100", {ISSUE_READY, BUSY_1, BUSY_2}); end
    step();
    ISSUE = 1'b0;
    vec++; if ({PENDING, BUSY_1} !== 2'b00) begin errs++; $display("FAIL r0_no_count got pend/busy=%b exp 00", {PENDING, BUSY_1}); end
    set_req(1, 5'd0, 32'h0000_1234);
    REQ_VALID = 3'b010;
    #1;
    vec++; if (REQ_READY !== 3'b010) begin errs++; $display("FAIL r0_ready got %b exp 010", REQ_READY); end
    step();
    REQ_VALID = 3'b111;
    #1;
    vec++; if ({WE, WR_ADDR, W_DATA} !== 38'd0) begin errs++; $display("FAIL r0_discard got we=%b addr=%0d data=%h exp 0/0/0", WE, WR_ADDR, W_DATA); end
    vec++; if (REQ_READY !== 3'b100) begin errs++; $display("FAIL r0_last_moved got %b exp 100", REQ_READY); end
    REQ_VALID = '0;
  endtask

  task automatic test_reset_mid();
    ISSUE = 1'b1; ISSUE_ADDR = 5'd3;
    set_req(0, 5'd3, 32'h0000_ABCD);
    REQ_VALID = 3'b001;
    step();
    ISSUE = 1'b0; REQ_VALID = '0;
    vec++; if ({WE, WR_ADDR, W_DATA, PENDING} !== {1'b1, 5'd3, 32'h0000_ABCD, 1'b1})
      begin errs++; $display("FAIL mid_pre got we=%b addr=%0d data=%h pend=%b exp 1/3/0000abcd/1", WE, WR_ADDR, W_DATA, PENDING); end
    #2;
    RESET_N = 1'b0;
    #1;
    vec++; if ({WE, WR_ADDR, W_DATA, PENDING} !== 39'd0)
      begin errs++; $display("FAIL mid_async got we=%b addr=%0d data=%h pend=%b exp 0/0/0/0", WE, WR_ADDR, W_DATA, PENDING); end
    step();
    @(negedge CLK);
    RESET_N = 1'b1;
    REQ_VALID = 3'b111;
    #1;
    vec++; if (REQ_READY !== 3'b001) begin errs++; $display("FAIL mid_grant got %b exp 001", REQ_READY); end
    REQ_VALID = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_scoreboard();
    test_saturation();
    test_simultaneous();
    test_r0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Write-back scheduler and scoreboard for the 32x32 register file. Arbitrates N write-back requesters (ALU, load unit, multiply/divide, ...) onto the single regfile write port with round-robin fairness and registered outputs. Tracks outstanding destination writes per register so decode can stall on read-after-write hazards. Sits between the execution units and the regfile write port; its busy outputs feed the decode stall logic.

## Interface
- N, 3: number of write-back requesters (2..8).
- CNT_W, 2: width of per-register pending-write counter; max outstanding writes per register = 2^CNT_W-1.
- CLK  in  1  clock, all state updates on rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- REQ_VALID  in  N  requester i has a write-back pending.
- REQ_ADDR  in  5*N  destination register of requester i, bits [5i+4:5i].
- REQ_DATA  in  32*N  write data of requester i, bits [32i+31:32i].
- REQ_READY  out  N  one-hot grant; transfer when REQ_VALID[i] && REQ_READY[i].
- ISSUE  in  1  decode issues an instruction that will write ISSUE_ADDR.
- ISSUE_ADDR  in  5  destination of issuing instruction.
- ISSUE_READY  out  1  scoreboard can accept ISSUE_ADDR.
- CHK_ADDR_1, CHK_ADDR_2  in  5  decode source registers to check.
- BUSY_1, BUSY_2  out  1  source has an uncommitted pending write.
- PENDING  out  1  any register counter nonzero.
- WE  out  1  to regfile write enable.
- WR_ADDR  out  5  to regfile write address.
- W_DATA  out  32  to regfile write data.

## Operation
- Arbiter: round-robin pointer LAST (index of last granted). Search order LAST+1, LAST+2, ... mod N; first requester with VALID gets READY. At most one READY bit high; READY[i] combinational from REQ_VALID and LAST, never high without VALID[i].
- On a transfer from requester g: LAST <= g; output register loads WE <= (REQ_ADDR_g != 0), WR_ADDR <= REQ_ADDR_g, W_DATA <= REQ_DATA_g.
- Transfer to r0: handshake completes, WE <= 0, WR_ADDR <= 0, W_DATA <= 0 (write discarded).
- No transfer: WE <= 0, WR_ADDR <= 0, W_DATA <= 0; LAST unchanged. Idle address forced to 0 so regfile bypass comparisons never hit a live register.
- Scoreboard: CNT[1..31], each CNT_W bits; r0 has no counter and is never busy.
- Increment CNT[ISSUE_ADDR] when ISSUE && ISSUE_READY && ISSUE_ADDR != 0.
- Decrement CNT[WR_ADDR] when registered WE is high and CNT[WR_ADDR] != 0 (write committed at this edge). Decrement at zero: counter stays 0 (unscoreboarded write still performed).
- Increment and decrement same register same edge: counter unchanged.
- ISSUE_READY = (ISSUE_ADDR == 0) || CNT[ISSUE_ADDR] != max. ISSUE while ISSUE_READY low: ignored, no state change.
- BUSY_k = (CHK_ADDR_k != 0) && CNT[CHK_ADDR_k] != 0, combinational from current counters.
- PENDING = OR of all counters != 0.

## Timing
- Reset (async assert, sync release): WE=0, WR_ADDR=0, W_DATA=0, all CNT=0, LAST=N-1 (requester 0 wins first), BUSY_1/2=0, PENDING=0; REQ_READY follows VALID (requester-0-first order), ISSUE_READY=1.
- Transfer in cycle t -> WE/WR_ADDR/W_DATA valid in cycle t+1; regfile commits at end of t+1.
- Counter decrements at end of t+1; BUSY for that register low from t+2 (counter was 1). Read address presented in t+2 returns committed data.
- ISSUE in cycle t -> BUSY visible from t+1.
- Throughput: one write-back per cycle, no bubbles under continuous requests.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,...,N-1,0,...; each requester waits at most N-1 cycles.
- Reset mid-operation: in-flight output write dropped (WE=0 immediately), scoreboard cleared.

## Test plan
- Reset: RESET_N low mid-run with WE=1 -> WE, WR_ADDR, W_DATA, PENDING go 0 asynchronously; after release, VALID=3'b111 -> READY=3'b001.
- Round-robin: N=3, all VALID held 6 cycles, addresses 5/6/7 -> WR_ADDR sequence 5,6,7,5,6,7 one cycle after each grant, WE=1 every cycle.
- Scoreboard: ISSUE r9 at t0 -> BUSY_1 (CHK_ADDR_1=9) high t1; requester 1 writes r9 data 0xDEADBEEF at t3 -> WE=1, W_DATA=0xDEADBEEF at t4, BUSY_1 low at t5, PENDING low at t5.
- Saturation: CNT_W=2, ISSUE r4 three times -> ISSUE_READY low for ISSUE_ADDR=4, fourth ISSUE ignored; ISSUE_ADDR=5 still ready; three writes to r4 -> BUSY clears only after third commit.
- Simultaneous: CNT[12]=1, registered WE to r12 and ISSUE r12 same cycle -> CNT[12] stays 1, BUSY stays high.
- r0: ISSUE r0 -> no counter change, BUSY for r0 always 0; request to r0 with data 0x1234 -> READY=1, next cycle WE=0, WR_ADDR=0, W_DATA=0.
